scr1_timer_mc: RTL and testbench

Multi-channel memory-mapped machine timer on the SCR1 data-memory bus. It keeps one free-running 64-bit mtime counter, clocked from a prescaled core clock or from a synchronised external RTC strobe. Around that counter sit NUM_CMP independent 64-bit compare channels, each running in one-shot (level) or periodic (auto-reload, sticky) mode. It sits beside the core's CSR/IPIC interrupt logic; channel 0 drives the machine timer interrupt and the remaining channels go to the IPIC.

---
 rtl/scr1_timer_mc_if.sv | 49 ++++
 rtl/scr1_timer_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_scr1_timer_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_timer_mc_if.sv
// Bus types and the SCR1 data-memory bus interface used by the multi-channel timer.

package scr1_timer_mc_pkg;

  localparam int unsigned DMEM_AWIDTH = 32;
  localparam int unsigned DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

interface scr1_timer_mc_if;

  logic                                      dmem_req;
  scr1_timer_mc_pkg::type_scr1_mem_cmd_e     dmem_cmd;
  scr1_timer_mc_pkg::type_scr1_mem_width_e   dmem_width;
  logic [scr1_timer_mc_pkg::DMEM_AWIDTH-1:0] dmem_addr;
  logic [scr1_timer_mc_pkg::DMEM_DWIDTH-1:0] dmem_wdata;
  logic                                      dmem_req_ack;
  logic [scr1_timer_mc_pkg::DMEM_DWIDTH-1:0] dmem_rdata;
  scr1_timer_mc_pkg::type_scr1_mem_resp_e    dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/scr1_timer_mc.sv
// Multi-channel machine timer: 64-bit mtime with prescaler/RTC source and
// NUM_CMP compare channels (one-shot level or periodic sticky auto-reload).

module scr1_timer_mc
  import scr1_timer_mc_pkg::*;
#(
  parameter int unsigned NUM_CMP   = 4,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rtc_in,
  scr1_timer_mc_if.slave     dmem,
  output logic [63:0]        timer_val,
  output logic [NUM_CMP-1:0] timer_irq
);

  // Address decode
  logic [7:0]               off;
  logic [3:0]               blk;
  logic [3:0]               ch_raw;
  logic [2:0]               ch_idx;
  logic [DMEM_AWIDTH-9:0]   unused_addr;
  logic                     word_ok;
  logic                     is_glob;
  logic                     is_ch;
  logic                     access_ok;
  logic                     wr;
  logic                     wr_ctrl;
  logic                     wr_div;
  logic                     wr_mlo;
  logic                     wr_mhi;
  logic                     wr_status;
  logic [31:0]              wdata;
  logic [31:0]              rdata_c;

  // Global state
  logic                     ctrl_en;
  logic                     ctrl_rtc;
  logic [DIV_WIDTH-1:0]     divider;
  logic [DIV_WIDTH-1:0]     cnt;
  logic [63:0]              mtime;
  logic [63:0]              mtime_inc;
  logic                     rtc_s1;
  logic                     rtc_s2;
  logic                     rtc_s3;
  logic                     rtc_pulse;
  logic                     cnt_en;
  logic                     tick;

  // Channel state
  logic [NUM_CMP-1:0][63:0] cmp_q;
  logic [NUM_CMP-1:0][63:0] cmp_post;
  logic [NUM_CMP-1:0][63:0] cmp_nxt;
  logic [NUM_CMP-1:0][63:0] reload;
  logic [NUM_CMP-1:0][31:0] period_q;
  logic [NUM_CMP-1:0]       ch_en;
  logic [NUM_CMP-1:0]       periodic;
  logic [NUM_CMP-1:0]       pending;
  logic [NUM_CMP-1:0]       pend_nxt;
  logic [NUM_CMP-1:0]       hit;
  logic [NUM_CMP-1:0]       wr_clo;
  logic [NUM_CMP-1:0]       wr_chi;
  logic [NUM_CMP-1:0]       wr_cctl;
  logic [NUM_CMP-1:0]       wr_cper;

  assign off         = dmem.dmem_addr[7:0];
  assign unused_addr = dmem.dmem_addr[DMEM_AWIDTH-1:8];
  assign wdata       = dmem.dmem_wdata;
  assign blk         = off[7:4];
  assign ch_raw      = blk - 4'd2;
  assign ch_idx      = ch_raw[2:0];
  assign word_ok     = (dmem.dmem_width == SCR1_MEM_WIDTH_WORD) && (off[1:0] == 2'b00);
  assign is_glob     = (blk == 4'h0) || ((blk == 4'h1) && (off[3:2] == 2'b00));
  assign is_ch       = (blk >= 4'h2) && (32'(ch_raw) < NUM_CMP);
  assign access_ok   = dmem.dmem_req && word_ok && (is_glob || is_ch);
  assign wr          = access_ok && (dmem.dmem_cmd == SCR1_MEM_CMD_WR);
  assign wr_ctrl     = wr && (off == 8'h00);
  assign wr_div      = wr && (off == 8'h04);
  assign wr_mlo      = wr && (off == 8'h08);
  assign wr_mhi      = wr && (off == 8'h0C);
  assign wr_status   = wr && (off == 8'h10);

  assign dmem.dmem_req_ack = 1'b1;

  // Prescaler enable: every clock, or one synchronised RTC rising edge
  assign rtc_pulse = rtc_s2 && !rtc_s3;
  assign cnt_en    = ctrl_en && (ctrl_rtc ? rtc_pulse : 1'b1);
  assign tick      = cnt_en && (cnt == '0);
  assign mtime_inc = mtime + 64'(tick);

  assign timer_val = mtime;
  // pending can only be set while CH_EN is set and is cleared with it
  assign timer_irq = pending;

  // Read data mux, reflects state before this cycle's write
  always_comb begin
    rdata_c = '0;
    case (off)
      8'h00:   rdata_c = {30'd0, ctrl_rtc, ctrl_en};
      8'h04:   rdata_c = 32'(divider);
      8'h08:   rdata_c = mtime[31:0];
      8'h0C:   rdata_c = mtime[63:32];
      8'h10:   rdata_c = 32'(pending);
      default: rdata_c = '0;
    endcase
    for (int i = 0; i < NUM_CMP; i++) begin
      if (is_ch && (ch_idx == 3'(i))) begin
        case (off[3:2])
          2'd0:    rdata_c = cmp_q[i][31:0];
          2'd1:    rdata_c = cmp_q[i][63:32];
          2'd2:    rdata_c = {30'd0, periodic[i], ch_en[i]};
          default: rdata_c = period_q[i];
        endcase
      end
    end
  end

  // Per-channel compare, reload and pending next-state
  always_comb begin
    cmp_post = cmp_q;
    cmp_nxt  = cmp_q;
    reload   = cmp_q;
    pend_nxt = pending;
    hit      = '0;
    wr_clo   = '0;
    wr_chi   = '0;
    wr_cctl  = '0;
    wr_cper  = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      wr_clo[i]   = wr && is_ch && (ch_idx == 3'(i)) && (off[3:2] == 2'd0);
      wr_chi[i]   = wr && is_ch && (ch_idx == 3'(i)) && (off[3:2] == 2'd1);
      wr_cctl[i]  = wr && is_ch && (ch_idx == 3'(i)) && (off[3:2] == 2'd2);
      wr_cper[i]  = wr && is_ch && (ch_idx == 3'(i)) && (off[3:2] == 2'd3);
      cmp_post[i] = {wr_chi[i] ? wdata : cmp_q[i][63:32],
                     wr_clo[i] ? wdata : cmp_q[i][31:0]};
      hit[i]      = ch_en[i] && (mtime >= cmp_post[i]);
      reload[i]   = cmp_post[i] + 64'(period_q[i]);
      cmp_nxt[i]  = cmp_post[i];
      if (periodic[i]) begin
        if (hit[i]) begin
          // set beats a same-cycle W1C; a CPU-written half beats the reload
          pend_nxt[i] = 1'b1;
          cmp_nxt[i]  = {wr_chi[i] ? wdata : reload[i][63:32],
                         wr_clo[i] ? wdata : reload[i][31:0]};
        end else if (wr_status && wdata[i]) begin
          pend_nxt[i] = 1'b0;
        end
      end else begin
        pend_nxt[i] = hit[i];
      end
      if (wr_cctl[i] && !wdata[0]) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  // All state registers and the registered bus response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem.dmem_rdata <= '0;
      ctrl_en         <= 1'b1;
      ctrl_rtc        <= 1'b0;
      divider         <= '0;
      cnt             <= '0;
      mtime           <= '0;
      rtc_s1          <= 1'b0;
      rtc_s2          <= 1'b0;
      rtc_s3          <= 1'b0;
      cmp_q           <= '0;
      period_q        <= '0;
      ch_en           <= '0;
      periodic        <= '0;
      pending         <= '0;
    end else begin
      rtc_s1 <= rtc_in;
      rtc_s2 <= rtc_s1;
      rtc_s3 <= rtc_s2;

      if (dmem.dmem_req) begin
        dmem.dmem_resp  <= access_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
        dmem.dmem_rdata <= (access_ok && (dmem.dmem_cmd == SCR1_MEM_CMD_RD)) ? rdata_c : '0;
      end else begin
        dmem.dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
        dmem.dmem_rdata <= '0;
      end

      if (wr_ctrl) begin
        ctrl_en  <= wdata[0];
        ctrl_rtc <= wdata[1];
      end
      if (wr_div) begin
        divider <= DIV_WIDTH'(wdata);
      end

      if (wr_div) begin
        cnt <= DIV_WIDTH'(wdata);
      end else if (tick) begin
        cnt <= divider;
      end else if (cnt_en) begin
        cnt <= cnt - DIV_WIDTH'(1);
      end

      mtime <= {wr_mhi ? wdata : mtime_inc[63:32],
                wr_mlo ? wdata : mtime_inc[31:0]};

      cmp_q   <= cmp_nxt;
      pending <= pend_nxt;
      for (int i = 0; i < NUM_CMP; i++) begin
        if (wr_cctl[i]) begin
          ch_en[i]    <= wdata[0];
          periodic[i] <= wdata[1];
        end
        if (wr_cper[i]) begin
          period_q[i] <= wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_scr1_timer_mc.sv
// Self-checking bench for scr1_timer_mc: randomized scenarios vs. an arithmetic reference.

module tb_scr1_timer_mc;
  import scr1_timer_mc_pkg::*;

  localparam int unsigned NUM_CMP   = 4;
  localparam int unsigned DIV_WIDTH = 16;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_DIV  = 32'h04;
  localparam logic [31:0] A_MLO  = 32'h08;
  localparam logic [31:0] A_MHI  = 32'h0C;
  localparam logic [31:0] A_STAT = 32'h10;

  logic               clk    = 1'b0;
  logic               rst    = 1'b1;
  logic               rtc_in = 1'b0;
  logic [63:0]        timer_val;
  logic [NUM_CMP-1:0] timer_irq;
  int                 n_checks = 0;
  int                 n_errors = 0;

  scr1_timer_mc_if bus_if ();

  scr1_timer_mc #(.NUM_CMP(NUM_CMP), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rtc_in    (rtc_in),
    .dmem      (bus_if.slave),
    .timer_val (timer_val),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ch_addr(input int ch, input int r);
    return 32'(32 + 16 * ch + 4 * r);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus request; returns the registered response sampled after the edge
  task automatic bus(input bit is_wr, input type_scr1_mem_width_e w, input logic [31:0] a,
                     input logic [31:0] d, output type_scr1_mem_resp_e r, output logic [31:0] q);
    bus_if.dmem_req   = 1'b1;
    bus_if.dmem_cmd   = is_wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    bus_if.dmem_width = w;
    bus_if.dmem_addr  = a;
    bus_if.dmem_wdata = d;
    @(posedge clk);
    #1;
    bus_if.dmem_req = 1'b0;
    r = bus_if.dmem_resp;
    q = bus_if.dmem_rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    type_scr1_mem_resp_e r;
    logic [31:0] q;
    bus(1'b1, SCR1_MEM_WIDTH_WORD, a, d, r, q);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q, output type_scr1_mem_resp_e r);
    bus(1'b0, SCR1_MEM_WIDTH_WORD, a, 32'h0, r, q);
  endtask

  // Stop mtime at 0 with the given divider and all channels disabled
  task automatic setup_frozen(input int d);
    wr(A_CTRL, 32'h0);
    wr(A_MLO, 32'h0);
    wr(A_MHI, 32'h0);
    wr(A_DIV, 32'(d));
    for (int ch = 0; ch < NUM_CMP; ch++) wr(ch_addr(ch, 2), 32'h0);
  endtask

  task automatic test_reset;
    logic [31:0] q;
    type_scr1_mem_resp_e r;
    step(2);
    n_checks++; if (timer_val !== 64'd0) begin n_errors++; $display("FAIL reset_timer_val: got %0d want 0", timer_val); end
    n_checks++; if (timer_irq !== '0) begin n_errors++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    n_checks++; if (bus_if.dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin n_errors++; $display("FAIL reset_resp: got %0d want 0", bus_if.dmem_resp); end
    n_checks++; if (bus_if.dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", bus_if.dmem_rdata); end
    rst = 1'b0;
    step(1);
    n_checks++; if (timer_val !== 64'd1) begin n_errors++; $display("FAIL first_tick: got %0d want 1", timer_val); end
    rd(A_CTRL, q, r);
    n_checks++; if (r !== SCR1_MEM_RESP_RDY_OK || q !== 32'h1) begin n_errors++; $display("FAIL ctrl_reset_read: got resp %0d data %h want 1/1", r, q); end
    rd(A_DIV, q, r);
    n_checks++; if (r !== SCR1_MEM_RESP_RDY_OK || q !== 32'h0) begin n_errors++; $display("FAIL div_reset_read: got resp %0d data %h want 1/0", r, q); end
    rd(A_STAT, q, r);
    n_checks++; if (q !== 32'h0) begin n_errors++; $display("FAIL status_reset_read: got %h want 0", q); end
  endtask

  task automatic test_prescaler;
    int d, d2, n, k_cnt, m_cnt, base;
    logic [63:0] exp;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 3 : int'($urandom_range(0, 6));
      setup_frozen(d);
      wr(A_CTRL, 32'h1);
      n = 0;
      k_cnt = int'($urandom_range(6, 20));
      for (int k = 0; k < k_cnt; k++) begin
        step(1);
        n++;
        exp = 64'(n / (d + 1));
        n_checks++; if (timer_val !== exp) begin n_errors++; $display("FAIL prescaler d=%0d n=%0d: got %0d want %0d", d, n, timer_val, exp); end
      end
      d2 = int'($urandom_range(0, 5));
      wr(A_DIV, 32'(d2));
      base = (n + 1) / (d + 1);
      m_cnt = int'($urandom_range(6, 20));
      for (int m = 1; m <= m_cnt; m++) begin
        step(1);
        exp = 64'(base + m / (d2 + 1));
        n_checks++; if (timer_val !== exp) begin n_errors++; $display("FAIL div_rewrite d=%0d d2=%0d m=%0d: got %0d want %0d", d, d2, m, timer_val, exp); end
      end
    end
  endtask

  task automatic test_mtime;
    logic [31:0] q;
    type_scr1_mem_resp_e r;
    setup_frozen(0);
    wr(A_MHI, 32'hFFFF_FFFF);
    wr(A_MLO, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    step(1);
    n_checks++; if (timer_val !== 64'd0) begin n_errors++; $display("FAIL mtime_wrap: got %h want 0", timer_val); end
    step(1);
    n_checks++; if (timer_val !== 64'd1) begin n_errors++; $display("FAIL mtime_after_wrap: got %h want 1", timer_val); end
    wr(A_CTRL, 32'h0);
    wr(A_MHI, 32'h5);
    wr(A_MLO, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    step(1);
    n_checks++; if (timer_val !== 64'h5_FFFF_FFFF) begin n_errors++; $display("FAIL mtime_carry_pre: got %h want 5ffffffff", timer_val); end
    wr(A_MLO, 32'h100);
    n_checks++; if (timer_val !== 64'h6_0000_0100) begin n_errors++; $display("FAIL mtime_write_with_tick: got %h want 600000100", timer_val); end
    rd(A_MLO, q, r);
    n_checks++; if (q !== 32'h100) begin n_errors++; $display("FAIL mtime_read_pre_tick: got %h want 100", q); end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_regs;
    logic [31:0] q, d;
    type_scr1_mem_resp_e r;
    int ch, sel, reg_i;
    setup_frozen(0);
    for (int it = 0; it < 10; it++) begin
      ch = int'($urandom_range(0, NUM_CMP - 1));
      sel = int'($urandom_range(0, 2));
      reg_i = (sel == 2) ? 3 : sel;
      d = $urandom;
      wr(ch_addr(ch, reg_i), d);
      rd(ch_addr(ch, reg_i), q, r);
      n_checks++; if (r !== SCR1_MEM_RESP_RDY_OK || q !== d) begin n_errors++; $display("FAIL reg_readback ch=%0d reg=%0d: got resp %0d data %h want 1/%h", ch, reg_i, r, q, d); end
    end
    wr(ch_addr(2, 2), 32'hFFFF_FFFC);
    rd(ch_addr(2, 2), q, r);
    n_checks++; if (q !== 32'h0) begin n_errors++; $display("FAIL chctrl_unused_bits: got %h want 0", q); end
    d = $urandom;
    wr(A_DIV, d);
    rd(A_DIV, q, r);
    n_checks++; if (q !== (d & 32'h0000_FFFF)) begin n_errors++; $display("FAIL div_width: got %h want %h", q, d & 32'h0000_FFFF); end
    d = $urandom;
    wr(A_MHI, d);
    rd(A_MHI, q, r);
    n_checks++; if (q !== d) begin n_errors++; $display("FAIL mtimehi_readback: got %h want %h", q, d); end
  endtask

  task automatic test_oneshot;
    int t, n;
    logic exp;
    setup_frozen(0);
    t = int'($urandom_range(5, 25));
    wr(ch_addr(0, 0), 32'(t));
    wr(ch_addr(0, 1), 32'h0);
    wr(ch_addr(0, 2), 32'h1);
    wr(A_CTRL, 32'h1);
    n = 0;
    for (int k = 0; k < t + 4; k++) begin
      step(1);
      n++;
      exp = ((n - 1) >= t);
      n_checks++; if (timer_irq !== {3'b000, exp}) begin n_errors++; $display("FAIL oneshot t=%0d n=%0d: got %b want %b", t, n, timer_irq, {3'b000, exp}); end
    end
    wr(ch_addr(0, 0), 32'd100);
    n_checks++; if (timer_irq[0] !== 1'b0) begin n_errors++; $display("FAIL oneshot_rewrite: got %b want 0", timer_irq[0]); end
  endtask

  task automatic test_periodic;
    localparam int D = 1;
    int n, p, coinc;
    logic [63:0] cmp_m, mt;
    logic pend_m, hit, w1c, last;
    logic [31:0] q;
    type_scr1_mem_resp_e r;
    setup_frozen(D);
    p = 5;
    wr(ch_addr(1, 0), 32'd20);
    wr(ch_addr(1, 1), 32'h0);
    wr(ch_addr(1, 3), 32'(p));
    wr(ch_addr(1, 2), 32'h3);
    wr(A_CTRL, 32'h1);
    n = 0;
    cmp_m = 64'd20;
    pend_m = 1'b0;
    coinc = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      mt = 64'(n / (D + 1));
      hit = (mt >= cmp_m);
      last = (cyc == 99);
      w1c = !last && pend_m && (hit || ($urandom_range(0, 3) == 0));
      if (w1c && hit) coinc++;
      if (last) begin
        rd(ch_addr(1, 0), q, r);
        n_checks++; if (q !== cmp_m[31:0]) begin n_errors++; $display("FAIL periodic_cmp_read: got %0d want %0d", q, cmp_m[31:0]); end
      end else if (w1c) begin
        wr(A_STAT, 32'h2);
      end else begin
        step(1);
      end
      n++;
      if (hit) begin
        pend_m = 1'b1;
        cmp_m = cmp_m + 64'(p);
      end else if (w1c) begin
        pend_m = 1'b0;
      end
      n_checks++; if (timer_irq !== {2'b00, pend_m, 1'b0}) begin n_errors++; $display("FAIL periodic n=%0d: got irq %b want %b (cmp %0d)", n, timer_irq, {2'b00, pend_m, 1'b0}, cmp_m); end
      n_checks++; if (timer_val !== 64'(n / (D + 1))) begin n_errors++; $display("FAIL periodic_mtime n=%0d: got %0d want %0d", n, timer_val, n / (D + 1)); end
    end
    if (coinc == 0) $display("note: no W1C/hit coincidence this run");
  endtask

  task automatic test_rtc;
    int rises, k;
    setup_frozen(0);
    wr(A_CTRL, 32'h3);
    rises = int'($urandom_range(3, 6));
    k = 0;
    for (int i = 0; i < rises; i++) begin
      rtc_in = 1'b1;
      step(2);
      n_checks++; if (timer_val !== 64'(k)) begin n_errors++; $display("FAIL rtc_latency_early rise=%0d: got %0d want %0d", i, timer_val, k); end
      step(1);
      k++;
      n_checks++; if (timer_val !== 64'(k)) begin n_errors++; $display("FAIL rtc_latency rise=%0d: got %0d want %0d", i, timer_val, k); end
      step(7);
      rtc_in = 1'b0;
      step(10);
      n_checks++; if (timer_val !== 64'(k)) begin n_errors++; $display("FAIL rtc_count rise=%0d: got %0d want %0d", i, timer_val, k); end
    end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_errors;
    logic [31:0] q;
    type_scr1_mem_resp_e r;
    bit                   e_wr[7]  = '{1, 1, 1, 1, 1, 0, 0};
    type_scr1_mem_width_e e_w[7]   = '{SCR1_MEM_WIDTH_BYTE, SCR1_MEM_WIDTH_HWORD, SCR1_MEM_WIDTH_WORD,
                                       SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_WORD,
                                       SCR1_MEM_WIDTH_BYTE};
    logic [31:0]          e_a[7]   = '{32'h04, 32'h04, 32'h02, 32'h60, 32'h14, 32'h66, 32'h00};
    setup_frozen(5);
    for (int i = 0; i < 7; i++) begin
      bus(e_wr[i], e_w[i], e_a[i], 32'h0000_0009, r, q);
      n_checks++; if (r !== SCR1_MEM_RESP_RDY_ER || q !== 32'h0) begin n_errors++; $display("FAIL bad_access %0d addr=%h: got resp %0d data %h want 2/0", i, e_a[i], r, q); end
    end
    rd(A_DIV, q, r);
    n_checks++; if (q !== 32'd5) begin n_errors++; $display("FAIL err_no_side_effect_div: got %0d want 5", q); end
    rd(A_CTRL, q, r);
    n_checks++; if (q !== 32'h0) begin n_errors++; $display("FAIL err_no_side_effect_ctrl: got %h want 0", q); end
    rd(32'h0000_0104, q, r);
    n_checks++; if (r !== SCR1_MEM_RESP_RDY_OK || q !== 32'd5) begin n_errors++; $display("FAIL high_addr_ignored: got resp %0d data %0d want 1/5", r, q); end
    n_checks++; if (timer_val !== 64'd0) begin n_errors++; $display("FAIL err_mtime_frozen: got %0d want 0", timer_val); end
    step(1);
    n_checks++; if (bus_if.dmem_resp !== SCR1_MEM_RESP_NOTRDY || bus_if.dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL idle_resp: got resp %0d data %h want 0/0", bus_if.dmem_resp, bus_if.dmem_rdata); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q;
    type_scr1_mem_resp_e r;
    setup_frozen(0);
    wr(ch_addr(2, 0), 32'd3);
    wr(ch_addr(2, 1), 32'h0);
    wr(ch_addr(2, 3), 32'd2);
    wr(ch_addr(2, 2), 32'h3);
    wr(A_CTRL, 32'h1);
    step(8);
    n_checks++; if (timer_irq[2] !== 1'b1) begin n_errors++; $display("FAIL pre_reset_irq: got %b want 1", timer_irq[2]); end
    bus_if.dmem_req   = 1'b1;
    bus_if.dmem_cmd   = SCR1_MEM_CMD_RD;
    bus_if.dmem_width = SCR1_MEM_WIDTH_WORD;
    bus_if.dmem_addr  = A_CTRL;
    step(1);
    n_checks++; if (bus_if.dmem_rdata !== 32'h1) begin n_errors++; $display("FAIL pre_reset_read: got %h want 1", bus_if.dmem_rdata); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (timer_val !== 64'd0) begin n_errors++; $display("FAIL mid_reset_timer_val: got %0d want 0", timer_val); end
    n_checks++; if (timer_irq !== '0) begin n_errors++; $display("FAIL mid_reset_irq: got %b want 0", timer_irq); end
    n_checks++; if (bus_if.dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin n_errors++; $display("FAIL mid_reset_resp: got %0d want 0", bus_if.dmem_resp); end
    n_checks++; if (bus_if.dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL mid_reset_rdata: got %h want 0", bus_if.dmem_rdata); end
    bus_if.dmem_req = 1'b0;
    step(2);
    rst = 1'b0;
    rd(ch_addr(2, 2), q, r);
    n_checks++; if (q !== 32'h0) begin n_errors++; $display("FAIL post_reset_chctrl: got %h want 0", q); end
    rd(ch_addr(2, 0), q, r);
    n_checks++; if (q !== 32'h0) begin n_errors++; $display("FAIL post_reset_cmp: got %h want 0", q); end
    rd(A_CTRL, q, r);
    n_checks++; if (q !== 32'h1) begin n_errors++; $display("FAIL post_reset_ctrl: got %h want 1", q); end
    rd(A_STAT, q, r);
    n_checks++; if (q !== 32'h0) begin n_errors++; $display("FAIL post_reset_status: got %h want 0", q); end
  endtask

  initial begin
    bus_if.dmem_req   = 1'b0;
    bus_if.dmem_cmd   = SCR1_MEM_CMD_RD;
    bus_if.dmem_width = SCR1_MEM_WIDTH_WORD;
    bus_if.dmem_addr  = 32'h0;
    bus_if.dmem_wdata = 32'h0;
    test_reset();
    test_prescaler();
    test_mtime();
    test_regs();
    test_oneshot();
    test_periodic();
    test_rtc();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
